// File: rtl/uart_rx.sv
// 8N1 serial receiver, LSB first. Mid-bit sampling from a synchronised line,
// with a holding register that has a ready/read handshake plus overrun and frame-error flags.
module uart_rx #(
   parameter int CLOCK_FREQUENCY = 50_000_000,
   parameter int BAUD_RATE       = 9600
) (
   input  logic       clkIn,
   input  logic       nRxResetIn,
   input  logic       rxIn,
   input  logic       rxReadIn,
   output logic [7:0] rxDataOut,
   output logic       rxValidOut,
   output logic       rxReadyOut,
   output logic       rxOverrunOut,
   output logic       rxFrameErrorOut,
   output logic       rxBusyOut
);

   localparam int BIT_CNT  = CLOCK_FREQUENCY / BAUD_RATE - 1;
   localparam int HALF_CNT = CLOCK_FREQUENCY / BAUD_RATE / 2 - 1;
   localparam int CNT_W    = $clog2(BIT_CNT + 1);
   localparam logic [CNT_W-1:0] BIT_LD  = CNT_W'(BIT_CNT);
   localparam logic [CNT_W-1:0] HALF_LD = CNT_W'(HALF_CNT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t           state;
   state_t           stateNext;
   logic             syncP0;
   logic             syncP1;
   logic             histP2;
   logic             vldP0;
   logic             vldP1;
   logic             fallEdge;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cntNext;
   logic [2:0]       bitIdx;
   logic [2:0]       bitIdxNext;
   logic [7:0]       shiftReg;
   logic             shiftEn;
   logic             commit;
   logic             frameErr;

   // Synchroniser stage: the history flop only arms once vldP1 says syncP1
   // holds a real line sample, so a line held low across reset release is no edge.
   always_ff @(posedge clkIn or negedge nRxResetIn) begin
      if (!nRxResetIn) begin
         syncP0 <= 1'b1;
         syncP1 <= 1'b1;
         histP2 <= 1'b0;
         vldP0  <= 1'b0;
         vldP1  <= 1'b0;
      end else begin
         syncP0 <= rxIn;
         syncP1 <= syncP0;
         histP2 <= syncP1 & vldP1;
         vldP0  <= 1'b1;
         vldP1  <= vldP0;
      end
   end

   assign fallEdge = histP2 & ~syncP1;

   always_ff @(posedge clkIn or negedge nRxResetIn) begin
      if (!nRxResetIn) begin
         state  <= IDLE;
         cnt    <= '0;
         bitIdx <= '0;
      end else begin
         state  <= stateNext;
         cnt    <= cntNext;
         bitIdx <= bitIdxNext;
      end
   end

   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      bitIdxNext = bitIdx;
      shiftEn    = 1'b0;
      commit     = 1'b0;
      frameErr   = 1'b0;
      case (state)
         IDLE: begin
            if (fallEdge) begin
               cntNext   = HALF_LD;
               stateNext = START;
            end
         end
         START: begin
            if (cnt == '0) begin
               if (syncP1) begin
                  stateNext = IDLE;
               end else begin
                  cntNext    = BIT_LD;
                  bitIdxNext = '0;
                  stateNext  = DATA;
               end
            end else begin
               cntNext = cnt - CNT_ONE;
            end
         end
         DATA: begin
            if (cnt == '0) begin
               shiftEn    = 1'b1;
               cntNext    = BIT_LD;
               bitIdxNext = bitIdx + 3'd1;
               if (bitIdx == 3'd7) begin
                  stateNext = STOP;
               end
            end else begin
               cntNext = cnt - CNT_ONE;
            end
         end
         STOP: begin
            if (cnt == '0) begin
               if (syncP1) begin
                  commit    = 1'b1;
                  stateNext = IDLE;
               end else begin
                  frameErr  = 1'b1;
                  stateNext = BREAK;
               end
            end else begin
               cntNext = cnt - CNT_ONE;
            end
         end
         BREAK: begin
            if (syncP1) begin
               stateNext = IDLE;
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clkIn) begin
      if (shiftEn) begin
         shiftReg <= {syncP1, shiftReg[7:1]};
      end
   end

   // Holding register stage: a commit outranks a same-cycle read, so the new byte stays unread.
   always_ff @(posedge clkIn or negedge nRxResetIn) begin
      if (!nRxResetIn) begin
         rxDataOut       <= 8'h00;
         rxValidOut      <= 1'b0;
         rxReadyOut      <= 1'b0;
         rxOverrunOut    <= 1'b0;
         rxFrameErrorOut <= 1'b0;
      end else begin
         rxValidOut      <= commit;
         rxFrameErrorOut <= frameErr;
         if (commit) begin
            rxDataOut  <= shiftReg;
            rxReadyOut <= 1'b1;
            if (rxReadyOut && !rxReadIn) begin
               rxOverrunOut <= 1'b1;
            end
         end else if (rxReadIn) begin
            rxReadyOut   <= 1'b0;
            rxOverrunOut <= 1'b0;
         end
      end
   end

   assign rxBusyOut = (state != IDLE);

endmodule
